axi_eth_txgen: RTL and testbench
================================

// Module: axi_eth_txgen
// PURPOSE
//  DMA-side transmit traffic source for the 10GbE datapath. It generates the AXI Ethernet
//  TX control stream (txc) and the frame data stream (txd) that the DMA MM2S channel normally
//  drives into axi_eth_ofm, so the TX path runs at line rate without the DMA.
//  Sits in the mm2s_clk domain and connects directly to the txc_*/txd_* slave ports.
// PARAMETERS
//  C_DST_MAC  48'hFFFF_FFFF_FFFF  destination MAC, bytes 0-5 (byte0 = C_DST_MAC[47:40])
//  C_SRC_MAC  48'h000A_3500_0001  source MAC, bytes 6-11
//  C_MAX_LEN  9018                max frame length in bytes; frame_len is clamped to this
//  C_IFG      4                   idle mm2s_clk cycles between frames (0 allowed)
// PORTS
//  mm2s_clk       in   1   clock, only clock of the block
//  mm2s_resetn    in   1   asynchronous reset, active-low
//  start          in   1   one-cycle pulse; starts a run, ignored while busy=1
//  stop           in   1   level; ends the run after the frame in flight completes
//  frame_len      in   14  frame length in bytes, excluding FCS; sampled at each frame start
//  frame_cnt      in   16  frames per run; 0 = continuous until stop
//  busy           out  1   run in progress
//  done           out  1   one-cycle pulse when a run ends
//  frames_sent    out  32  frames completed since reset; wraps at 2^32
//  txc_tdata      out  32  control stream data
//  txc_tkeep      out  4   always 4'hF
//  txc_tvalid     out  1   control stream valid
//  txc_tlast      out  1   marks the sixth control word
//  txc_tready     in   1   from axi_eth_ofm
//  txd_tdata      out  64  frame data; byte n of a beat in [8n+7:8n]
//  txd_tkeep      out  8   byte enables; contiguous from bit 0
//  txd_tvalid     out  1   data stream valid
//  txd_tlast      out  1   marks the last data beat
//  txd_tready     in   1   from axi_eth_ofm
//  txgen_fsm_dbg  out  4   current FSM state encoding, for ILA
// BEHAVIOUR
//  Reset (async assert, release synchronous to mm2s_clk):
//   - all outputs 0; state IDLE; frames_sent = 0.
//  FSM: IDLE -> CTRL -> DATA -> GAP -> (CTRL | IDLE). Encodings 0..3, driven on txgen_fsm_dbg.
//   - IDLE: on start, latch frame_cnt, set busy, go to CTRL in the next cycle.
//   - CTRL: send 6 words. Word0 = 32'hA000_0000, words 1-5 = 0. tlast on word 5.
//     A word advances only on txc_tvalid & txc_tready. After word 5, go to DATA.
//   - DATA: L = clamp(frame_len, 14, C_MAX_LEN), sampled on entry to CTRL.
//     Send ceil(L/8) beats. Bytes 0-11 are the MACs. Bytes 12-13 = (L-14), big-endian.
//     Byte i >= 14 = (seq[7:0] + i - 14) mod 256, where seq = frames_sent[7:0] at frame start.
//     Last beat: tlast=1, tkeep = (L%8==0) ? 8'hFF : (8'hFF >> (8 - L%8)). Other beats: tkeep=8'hFF.
//     frames_sent increments on the last-beat handshake.
//   - GAP: wait C_IFG cycles (skipped when C_IFG=0). Then:
//     -> IDLE if (frame_cnt!=0 and remaining==0) or stop=1; otherwise -> CTRL.
//     done pulses in the cycle busy falls.
//  Handshake rules:
//   - Once tvalid rises, tvalid, tdata, tkeep and tlast hold until tready.
//   - txc and txd are never valid in the same cycle.
//   - The first txd beat may be presented in the cycle after the txc word-5 handshake.
//   - With tready held at 1, a 64-byte frame takes 6 + 8 beats + C_IFG cycles.
//  Boundary conditions:
//   - stop during CTRL or DATA: the frame completes; no truncation.
//   - stop in IDLE: no effect.
//   - start and stop in the same cycle in IDLE: the run starts, sends one frame, then ends.
//   - The frame_len change takes effect at the next CTRL entry.
//   - The remaining-frame count is 16 bits; in continuous mode it is not decremented.
//   - Reset mid-frame abandons the frame; axi_eth_ofm is reset together with this block.
// CONFIGURATION
//  AXI_ETH_TXGEN_PRBS_EN defined:
//   - payload bytes i >= 14 come from a PRBS-31 LFSR (x^31+x^28+1), advanced 64 bits per beat.
//   - The LFSR is seeded to 31'h7FFF_FFFF at reset and at each run start.
//  AXI_ETH_TXGEN_PRBS_EN undefined:
//   - incrementing pattern as above; no LFSR logic is present.
// STRUCTURE
//  Package axi_eth_pkg:
//   - FSM state encodings.
//   - TXC_FLAG_NORMAL = 32'hA000_0000.
//   - TXC_WORDS = 6.
//   - ETH_HDR_LEN = 14.
//  One sub-module, axi_eth_txgen_beat: combinational beat builder. Inputs: beat index, L, seq, LFSR.
//  Outputs: tdata, tkeep, last. Instantiated once.
// TESTING
//  1. start, len=64, cnt=1, tready=1 -> txc words A0000000,0x5 (tlast on 6th); 8 txd beats, last tkeep FF; done; frames_sent=1.
//  2. len=61, cnt=2 -> 8 beats/frame, last tkeep 8'h1F, bytes12-13=00 2F; frame 2 payload byte14=0x01; frames_sent=2.
//  3. Random tready backpressure on txc and txd -> tdata/tkeep/tlast stable while tvalid & !tready; no txc/txd overlap.
//  4. cnt=0, len=9100, stop after 3 frames -> length clamped to 9018 (1128 beats, last tkeep 8'h03), run ends after the frame in flight.
//  5. len=5 -> clamped to 14: 2 beats, last tkeep 8'h3F, bytes12-13=00 00.
//  6. Reset asserted mid-DATA -> all outputs 0 immediately; fresh start after release gives frame 1 of case 1 exactly.

Source files
------------

// File: rtl/axi_eth_pkg.sv
// Shared encodings and helpers for the AXI Ethernet TX traffic generator.
// AXI_ETH_TXGEN_PRBS_EN adds the PRBS-31 payload helpers.
package axi_eth_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CTRL = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } txgen_state_e;

    localparam logic [31:0] TXC_FLAG_NORMAL = 32'hA000_0000;
    localparam int          TXC_WORDS       = 6;
    localparam logic [13:0] ETH_HDR_LEN     = 14'd14;
    localparam int          BEAT_W          = 11;

    function automatic logic [13:0] clamp_len(input logic [13:0] len, input logic [13:0] max_len);
        if (len < ETH_HDR_LEN) return ETH_HDR_LEN;
        if (len > max_len) return max_len;
        return len;
    endfunction

`ifdef AXI_ETH_TXGEN_PRBS_EN
    localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

    // Fibonacci x^31+x^28+1; bit k of a beat is the k-th generated bit.
    function automatic logic [63:0] prbs_bits(input logic [30:0] s);
        logic [30:0] st;
        logic        nb;
        logic [63:0] r;
        st = s;
        r  = '0;
        for (int k = 0; k < 64; k++) begin
            nb    = st[30] ^ st[27];
            st    = {st[29:0], nb};
            r[k]  = nb;
        end
        return r;
    endfunction

    function automatic logic [30:0] prbs_advance(input logic [30:0] s);
        logic [30:0] st;
        st = s;
        for (int k = 0; k < 64; k++) st = {st[29:0], st[30] ^ st[27]};
        return st;
    endfunction
`endif
endpackage

// File: rtl/axi_eth_txgen_beat.sv
// Combinational builder for one 64-bit txd beat: MAC header, length field, payload.
// AXI_ETH_TXGEN_PRBS_EN selects PRBS payload instead of the incrementing pattern.
module axi_eth_txgen_beat
    import axi_eth_pkg::*;
#(
    parameter logic [47:0] C_DST_MAC = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] C_SRC_MAC = 48'h000A_3500_0001
) (
    input  logic [BEAT_W-1:0] beat_idx,
    input  logic [13:0]       len,
`ifdef AXI_ETH_TXGEN_PRBS_EN
    input  logic [30:0]       lfsr,
`else
    input  logic [7:0]        seq,
`endif
    output logic [63:0]       tdata,
    output logic [7:0]        tkeep,
    output logic              last
);
    localparam logic [95:0] HDR = {C_DST_MAC, C_SRC_MAC};

    logic [13:0]       len_field;
    logic [14:0]       len_up;
    logic [11:0]       nbeats;
    logic [BEAT_W-1:0] last_idx;

    assign len_field = len - ETH_HDR_LEN;
    assign len_up    = {1'b0, len} + 15'd7;
    assign nbeats    = len_up[14:3];
    assign last_idx  = BEAT_W'(nbeats - 12'd1);
    assign last      = (beat_idx == last_idx);

    always_comb begin
        tkeep = 8'hFF;
        if (last && (len[2:0] != 3'd0)) tkeep = 8'hFF >> (4'd8 - {1'b0, len[2:0]});
    end

`ifdef AXI_ETH_TXGEN_PRBS_EN
    logic [63:0] prbs_w;
    assign prbs_w = prbs_bits(lfsr);
`endif

    for (genvar n = 0; n < 8; n++) begin : g_lane
        logic [13:0] idx;
        logic [7:0]  pay;
        logic [7:0]  byte_v;

        assign idx = {beat_idx, 3'(n)};
`ifdef AXI_ETH_TXGEN_PRBS_EN
        assign pay = prbs_w[8*n +: 8];
`else
        assign pay = seq + idx[7:0] - 8'd14;
`endif
        always_comb begin
            if (idx < 14'd12)       byte_v = HDR[8*(11 - int'(idx[3:0])) +: 8];
            else if (idx == 14'd12) byte_v = {2'b00, len_field[13:8]};
            else if (idx == 14'd13) byte_v = len_field[7:0];
            else                    byte_v = pay;
        end
        // bytes past the frame end are driven as zero
        assign tdata[8*n +: 8] = tkeep[n] ? byte_v : 8'h00;
    end
endmodule

// File: rtl/axi_eth_txgen.sv
// Line-rate TX traffic source driving the AXI Ethernet txc/txd streams in place of the DMA.
// Define AXI_ETH_TXGEN_PRBS_EN for PRBS-31 payload; default is an incrementing byte pattern.
module axi_eth_txgen
    import axi_eth_pkg::*;
#(
    parameter logic [47:0] C_DST_MAC = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] C_SRC_MAC = 48'h000A_3500_0001,
    parameter int          C_MAX_LEN = 9018,
    parameter int          C_IFG     = 4
) (
    input  logic        mm2s_clk,
    input  logic        mm2s_resetn,
    input  logic        start,
    input  logic        stop,
    input  logic [13:0] frame_len,
    input  logic [15:0] frame_cnt,
    output logic        busy,
    output logic        done,
    output logic [31:0] frames_sent,
    output logic [31:0] txc_tdata,
    output logic [3:0]  txc_tkeep,
    output logic        txc_tvalid,
    output logic        txc_tlast,
    input  logic        txc_tready,
    output logic [63:0] txd_tdata,
    output logic [7:0]  txd_tkeep,
    output logic        txd_tvalid,
    output logic        txd_tlast,
    input  logic        txd_tready,
    output logic [3:0]  txgen_fsm_dbg
);
    localparam int               GAP_W    = (C_IFG > 1) ? $clog2(C_IFG) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((C_IFG > 0) ? C_IFG - 1 : 0);
    localparam logic [13:0]      MAX_LEN  = 14'(C_MAX_LEN);

    txgen_state_e      state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              stop_req_q, stop_req_d, cont_q, cont_d;
    logic [31:0]       frames_sent_q, frames_sent_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [2:0]        word_q, word_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [13:0]       len_q, len_d;
    logic              txc_hs, txd_hs, run_start, frame_done, enter_ctrl;
    logic [63:0]       beat_data;
    logic [7:0]        beat_keep;
    logic              beat_last;

    assign txc_tvalid    = (state_q == ST_CTRL);
    assign txc_tdata     = (txc_tvalid && word_q == 3'd0) ? TXC_FLAG_NORMAL : 32'h0;
    assign txc_tkeep     = txc_tvalid ? 4'hF : 4'h0;
    assign txc_tlast     = txc_tvalid && (word_q == 3'(TXC_WORDS - 1));
    assign txd_tvalid    = (state_q == ST_DATA);
    assign txd_tdata     = txd_tvalid ? beat_data : 64'h0;
    assign txd_tkeep     = txd_tvalid ? beat_keep : 8'h0;
    assign txd_tlast     = txd_tvalid & beat_last;
    assign txc_hs        = txc_tvalid & txc_tready;
    assign txd_hs        = txd_tvalid & txd_tready;
    assign run_start     = (state_q == ST_IDLE) & start;
    assign busy          = busy_q;
    assign done          = done_q;
    assign frames_sent   = frames_sent_q;
    assign txgen_fsm_dbg = {2'b00, state_q};

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        stop_req_d    = stop_req_q;
        cont_d        = cont_q;
        frames_sent_d = frames_sent_q;
        remaining_d   = remaining_q;
        word_d        = word_q;
        beat_d        = beat_q;
        gap_d         = gap_q;
        len_d         = len_q;
        frame_done    = 1'b0;
        enter_ctrl    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                busy_d      = 1'b1;
                cont_d      = (frame_cnt == 16'd0);
                remaining_d = frame_cnt;
                stop_req_d  = stop;
                enter_ctrl  = 1'b1;
            end
            ST_CTRL: if (txc_hs) begin
                if (word_q == 3'(TXC_WORDS - 1)) state_d = ST_DATA;
                else word_d = word_q + 3'd1;
            end
            ST_DATA: if (txd_hs) begin
                beat_d = beat_q + 1'b1;
                if (beat_last) begin
                    beat_d        = '0;
                    frames_sent_d = frames_sent_q + 32'd1;
                    if (!cont_q) remaining_d = remaining_q - 16'd1;
                    if (C_IFG == 0) frame_done = 1'b1;
                    else begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) frame_done = 1'b1;
                else gap_d = gap_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // a stop seen at any point of the run ends it after the current frame
        if (stop && busy_q) stop_req_d = 1'b1;
        if (frame_done) begin
            if (stop || stop_req_q || (!cont_q && remaining_d == 16'd0)) begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                stop_req_d = 1'b0;
            end else begin
                enter_ctrl = 1'b1;
            end
        end
        if (enter_ctrl) begin
            state_d = ST_CTRL;
            word_d  = '0;
            len_d   = clamp_len(frame_len, MAX_LEN);
        end
    end

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            stop_req_q    <= 1'b0;
            cont_q        <= 1'b0;
            frames_sent_q <= '0;
            remaining_q   <= '0;
            word_q        <= '0;
            beat_q        <= '0;
            gap_q         <= '0;
            len_q         <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            stop_req_q    <= stop_req_d;
            cont_q        <= cont_d;
            frames_sent_q <= frames_sent_d;
            remaining_q   <= remaining_d;
            word_q        <= word_d;
            beat_q        <= beat_d;
            gap_q         <= gap_d;
            len_q         <= len_d;
        end
    end

`ifdef AXI_ETH_TXGEN_PRBS_EN
    logic [30:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (run_start) lfsr_d = PRBS_SEED;
        else if (txd_hs) lfsr_d = prbs_advance(lfsr_q);
    end

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) lfsr_q <= PRBS_SEED;
        else              lfsr_q <= lfsr_d;
    end
`else
    logic [7:0] seq_q, seq_d;

    // seq follows frames_sent at CTRL entry, including the increment of a frame ending this cycle
    always_comb begin
        seq_d = seq_q;
        if (enter_ctrl) seq_d = frames_sent_d[7:0];
    end

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) seq_q <= '0;
        else              seq_q <= seq_d;
    end
`endif

    axi_eth_txgen_beat #(
        .C_DST_MAC (C_DST_MAC),
        .C_SRC_MAC (C_SRC_MAC)
    ) u_beat (
        .beat_idx (beat_q),
        .len      (len_q),
`ifdef AXI_ETH_TXGEN_PRBS_EN
        .lfsr     (lfsr_q),
`else
        .seq      (seq_q),
`endif
        .tdata    (beat_data),
        .tkeep    (beat_keep),
        .last     (beat_last)
    );
endmodule

// File: tb/tb_axi_eth_txgen.sv
// Self-checking bench for axi_eth_txgen: frame-level byte model plus directed literal checks.
module tb_axi_eth_txgen;
    localparam logic [47:0] DST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC  = 48'h000A_3500_0001;
    localparam int          MAXL = 9018;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [13:0] frame_len = 14'd64;
    logic [15:0] frame_cnt = 16'd1;
    logic        busy, done;
    logic [31:0] frames_sent;
    logic [31:0] txc_tdata;
    logic [3:0]  txc_tkeep;
    logic        txc_tvalid, txc_tlast;
    logic        txc_tready = 1'b1;
    logic [63:0] txd_tdata;
    logic [7:0]  txd_tkeep;
    logic        txd_tvalid, txd_tlast;
    logic        txd_tready = 1'b1;
    logic [3:0]  txgen_fsm_dbg;

    always #5 clk = ~clk;

    axi_eth_txgen dut (
        .mm2s_clk      (clk),
        .mm2s_resetn   (rst_n),
        .start         (start),
        .stop          (stop),
        .frame_len     (frame_len),
        .frame_cnt     (frame_cnt),
        .busy          (busy),
        .done          (done),
        .frames_sent   (frames_sent),
        .txc_tdata     (txc_tdata),
        .txc_tkeep     (txc_tkeep),
        .txc_tvalid    (txc_tvalid),
        .txc_tlast     (txc_tlast),
        .txc_tready    (txc_tready),
        .txd_tdata     (txd_tdata),
        .txd_tkeep     (txd_tkeep),
        .txd_tvalid    (txd_tvalid),
        .txd_tlast     (txd_tlast),
        .txd_tready    (txd_tready),
        .txgen_fsm_dbg (txgen_fsm_dbg)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    int          checks = 0, errors = 0;
    beat_t       exp_d[$];
    logic [32:0] exp_c[$];
    logic [63:0] got_d[$], c1_d[$];
    logic [7:0]  got_k[$];
    logic [31:0] got_c[$];
    logic [31:0] model_frames = 0;
    bit          rnd_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clampf(input int len);
        return (len < 14) ? 14 : ((len > MAXL) ? MAXL : len);
    endfunction

    function automatic logic [63:0] keepmask(input logic [7:0] k);
        logic [63:0] m;
        for (int n = 0; n < 8; n++) m[8*n +: 8] = {8{k[n]}};
        return m;
    endfunction

    // Build the frame as a byte array, then slice into beats
    task automatic push_frame(input int len_in, input int seqn);
        int          L, nb;
        logic [95:0] hdr;
        logic [7:0]  fb[];
        beat_t       bt;
        L   = clampf(len_in);
        hdr = {DST, SRC};
        fb  = new[L];
        for (int i = 0; i < L; i++) begin
            if (i < 12)       fb[i] = hdr[95 - 8*i -: 8];
            else if (i == 12) fb[i] = 8'((L - 14) >> 8);
            else if (i == 13) fb[i] = 8'(L - 14);
            else              fb[i] = 8'(seqn + i - 14);
        end
        for (int w = 0; w < 6; w++) exp_c.push_back({1'(w == 5), (w == 0) ? 32'hA000_0000 : 32'h0});
        nb = (L + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            bt.data = '0;
            bt.keep = '0;
            bt.last = (b == nb - 1);
            for (int n = 0; n < 8; n++)
                if (8*b + n < L) begin
                    bt.data[8*n +: 8] = fb[8*b + n];
                    bt.keep[n]        = 1'b1;
                end
            exp_d.push_back(bt);
        end
    endtask

    // Compare process
    logic        pc_pend = 0, pd_pend = 0, prev_busy = 0;
    logic [37:0] pc_snap;
    logic [9:0]  pd_ctl;
    logic [63:0] pd_dat;
    beat_t       e;
    logic [32:0] ec;

    always @(negedge clk) begin
        if (!rst_n) begin
            pc_pend   = 0;
            pd_pend   = 0;
            prev_busy = 0;
        end else begin
            chk("frames_sent_model", frames_sent, 64'(model_frames));
            chk("txc_txd_overlap", 64'(txc_tvalid & txd_tvalid), 0);
            if (pc_pend) chk("txc_hold", {txc_tvalid, txc_tdata, txc_tkeep, txc_tlast}, 64'(pc_snap));
            if (pd_pend) begin
                chk("txd_hold_ctl", {txd_tvalid, txd_tkeep, txd_tlast}, 64'(pd_ctl));
                chk("txd_hold_data", txd_tdata, pd_dat);
            end
            if (done) chk("done_on_busy_fall", {prev_busy, busy}, 64'b10);
            if (txc_tvalid) chk("txc_tkeep", txc_tkeep, 64'hF);
            if (txc_tvalid && txc_tready) begin
                if (exp_c.size() == 0) push_frame(int'(frame_len), int'(model_frames[7:0]));
                ec = exp_c.pop_front();
                chk("txc_word", {txc_tlast, txc_tdata}, 64'(ec));
                got_c.push_back(txc_tdata);
            end
            if (txd_tvalid && txd_tready) begin
                if (exp_d.size() == 0) chk("txd_unexpected_beat", 1, 0);
                else begin
                    e = exp_d.pop_front();
                    chk("txd_keep", txd_tkeep, e.keep);
                    chk("txd_last", txd_tlast, e.last);
                    chk("txd_data", txd_tdata & keepmask(e.keep), e.data);
                    if (e.last) model_frames++;
                end
                got_d.push_back(txd_tdata);
                got_k.push_back(txd_tkeep);
            end
            pc_pend   = txc_tvalid & !txc_tready;
            pc_snap   = {txc_tvalid, txc_tdata, txc_tkeep, txc_tlast};
            pd_pend   = txd_tvalid & !txd_tready;
            pd_ctl    = {txd_tvalid, txd_tkeep, txd_tlast};
            pd_dat    = txd_tdata;
            prev_busy = busy;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_en) begin
            txc_tready = 1'($urandom);
            txd_tready = 1'($urandom_range(0, 1));
        end else begin
            txc_tready = 1'b1;
            txd_tready = 1'b1;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ctl", {busy, done, txc_tvalid, txc_tlast, txd_tvalid, txd_tlast,
                        txc_tkeep, txd_tkeep, txgen_fsm_dbg}, 0);
        chk("rst_frames_sent", frames_sent, 0);
        chk("rst_txc_tdata", txc_tdata, 0);
        chk("rst_txd_tdata", txd_tdata, 0);
        exp_c.delete();
        exp_d.delete();
        model_frames = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic clear_got();
        got_d.delete();
        got_k.delete();
        got_c.delete();
    endtask

    task automatic kick(input int len, input int cnt, input logic with_stop);
        frame_len = 14'(len);
        frame_cnt = 16'(cnt);
        clear_got();
        @(posedge clk);
        #1 start = 1'b1;
        stop = with_stop;
        @(posedge clk);
        #1 start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic wait_txd(input int budget);
        int c;
        c = 0;
        while (!txd_tvalid && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!txd_tvalid) chk("txd_wait_timeout", 0, 1);
    endtask

    int          cyc, fs0, c;
    logic [63:0] d64;

    initial begin
        do_reset();

        // 1: single 64-byte frame
        kick(64, 1, 1'b0);
        wait_done(100, cyc);
        chk("c1_cycles", cyc, 18);
        chk("c1_txc_words", got_c.size(), 6);
        chk("c1_txc_w0", got_c[0], 64'hA000_0000);
        chk("c1_beats", got_d.size(), 8);
        chk("c1_beat0", got_d[0], 64'h0A00_FFFF_FFFF_FFFF);
        chk("c1_beat1", got_d[1], 64'h0100_3200_0100_0035);
        chk("c1_last_keep", got_k[7], 64'hFF);
        @(posedge clk);
        #1 chk("c1_frames_sent", frames_sent, 1);
        chk("c1_busy_low", busy, 0);
        c1_d = got_d;

        // 2: 61-byte frames, two per run
        do_reset();
        kick(61, 2, 1'b0);
        wait_done(200, cyc);
        chk("c2_beats", got_d.size(), 16);
        chk("c2_keep_f1", got_k[7], 64'h1F);
        chk("c2_keep_f2", got_k[15], 64'h1F);
        d64 = got_d[1];
        chk("c2_lenfield", d64[47:32], 64'h2F00);
        d64 = got_d[9];
        chk("c2_f2_byte14", d64[55:48], 64'h01);
        @(posedge clk);
        #1 chk("c2_frames_sent", frames_sent, 2);

        // 3: random backpressure
        fs0    = int'(frames_sent);
        rnd_en = 1;
        kick(30, 3, 1'b0);
        wait_done(3000, cyc);
        rnd_en = 0;
        chk("c3_beats", got_d.size(), 12);
        chk("c3_last_keep", got_k[11], 64'h3F);
        @(posedge clk);
        #1 chk("c3_frames", frames_sent - fs0, 3);

        // 4: continuous, clamped length, stop during third frame
        fs0 = int'(model_frames);
        kick(9100, 0, 1'b0);
        c = 0;
        while (int'(model_frames) < fs0 + 2 && c < 5000) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("c4_two_frames_seen", 64'(int'(model_frames) >= fs0 + 2), 1);
        repeat (200) @(posedge clk);
        #1 stop = 1'b1;
        wait_done(3000, cyc);
        stop = 1'b0;
        chk("c4_beats", got_d.size(), 3 * 1128);
        chk("c4_last_keep", got_k[1127], 64'h03);
        @(posedge clk);
        #1 chk("c4_frames", int'(model_frames) - fs0, 3);

        // 5: short frame clamped up to header length
        kick(5, 1, 1'b0);
        wait_done(100, cyc);
        chk("c5_beats", got_d.size(), 2);
        chk("c5_last_keep", got_k[1], 64'h3F);
        d64 = got_d[1];
        chk("c5_lenfield", d64[47:32], 64'h0000);

        // stop while idle has no effect
        fs0 = int'(frames_sent);
        @(posedge clk);
        #1 stop = 1'b1;
        repeat (3) @(posedge clk);
        #1 stop = 1'b0;
        chk("idle_stop_busy", {busy, txc_tvalid, txgen_fsm_dbg}, 0);
        chk("idle_stop_frames", frames_sent, 64'(fs0));

        // start with stop in the same cycle, continuous mode: one frame only
        kick(64, 0, 1'b1);
        wait_done(200, cyc);
        chk("ss_beats", got_d.size(), 8);
        @(posedge clk);
        #1 chk("ss_frames", frames_sent - fs0, 1);

        // stop during DATA: frame completes
        fs0 = int'(frames_sent);
        kick(64, 5, 1'b0);
        wait_txd(50);
        stop = 1'b1;
        wait_done(200, cyc);
        stop = 1'b0;
        chk("sd_beats", got_d.size(), 8);
        @(posedge clk);
        #1 chk("sd_frames", frames_sent - fs0, 1);

        // 6: reset mid-DATA, then a fresh case-1 frame
        kick(64, 1, 1'b0);
        wait_txd(50);
        repeat (2) @(posedge clk);
        do_reset();
        kick(64, 1, 1'b0);
        wait_done(100, cyc);
        chk("c6_cycles", cyc, 18);
        chk("c6_beats", got_d.size(), 8);
        for (int i = 0; i < 8 && i < got_d.size() && i < c1_d.size(); i++)
            chk("c6_same_as_c1", got_d[i], c1_d[i]);
        @(posedge clk);
        #1 chk("c6_frames_sent", frames_sent, 1);

        chk("exp_txd_drained", exp_d.size(), 0);
        chk("exp_txc_drained", exp_c.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
